alu_issue_ctrl: RTL

//  Issue/sequencing controller in front of the ALU stage.
//  - Decides each cycle whether the decoded instruction may enter the ALU stage register.
//  - Drives the ALU stage's enable and write-enable inputs.
//  - Tracks in-flight destination registers in an 8-entry scoreboard and stalls decode on RAW/WAW hazards.
//  - Holds the ALU stage for multi-cycle opcodes.

---
 rtl/alu_issue_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issue/sequencing controller with RAW/WAW scoreboard ahead of the ALU stage
module alu_issue_ctrl #(
    parameter logic [3:0] MULTI_COP  = 4'b0110,
    parameter int         MC_LATENCY = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dec_valid,
    input  logic [3:0] dec_cop,
    input  logic [2:0] dec_srcA,
    input  logic [2:0] dec_srcB,
    input  logic       dec_usesB,
    input  logic       dec_we,
    input  logic [2:0] dec_dest,
    input  logic       wb_we,
    input  logic [2:0] wb_addr,
    input  logic       flush,
    output logic       enable_alu,
    output logic       alu_we,
    output logic       issue,
    output logic       stall_dec,
    output logic       alu_busy,
    output logic       res_valid,
    output logic [7:0] pending
);

    typedef enum logic {
        ST_READY = 1'b0,
        ST_BUSY  = 1'b1
    } state_t;

    // Countdown starts two below the latency: the issue cycle and the final BUSY cycle are not counted.
    localparam logic [3:0] CNT_INIT = 4'(MC_LATENCY - 2);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] pending_q, pending_d;
    logic       res_valid_q, res_valid_d;

    logic       hazard;
    logic       is_multi;
    logic       in_reset;

    // Hazard detection and issue decision from registered state only.
    always_comb begin
        in_reset   = ~reset;
        is_multi   = (dec_cop == MULTI_COP);
        hazard     = pending_q[dec_srcA]
                   | (dec_usesB & pending_q[dec_srcB])
                   | (dec_we & pending_q[dec_dest]);
        issue      = ~in_reset & (state_q == ST_READY) & dec_valid & ~hazard & ~flush;
        stall_dec  = dec_valid & ~issue;
        alu_we     = issue & dec_we;
        enable_alu = ~in_reset & (state_q == ST_READY);
        alu_busy   = ~in_reset & (state_q == ST_BUSY);
        pending    = pending_q;
        res_valid  = res_valid_q;
    end

    // Next-state: FSM, multi-cycle countdown, scoreboard and result-valid pulse.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pending_d   = pending_q;
        res_valid_d = 1'b0;

        if (in_reset || flush) begin
            state_d   = ST_READY;
            cnt_d     = 4'd0;
            pending_d = 8'h00;
        end else begin
            // Clear first so a same-edge set to the same register wins.
            if (wb_we) begin
                pending_d[wb_addr] = 1'b0;
            end
            if (issue && dec_we) begin
                pending_d[dec_dest] = 1'b1;
            end

            case (state_q)
                ST_READY: begin
                    if (issue && is_multi) begin
                        state_d = ST_BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end
                ST_BUSY: begin
                    if (cnt_q == 4'd0) begin
                        state_d = ST_READY;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d = ST_READY;
                    cnt_d   = 4'd0;
                end
            endcase

            // Single-cycle ops finish one cycle after issue; multi-cycle ops flag the last BUSY cycle.
            res_valid_d = (issue & ~is_multi) | ((state_d == ST_BUSY) & (cnt_d == 4'd0));
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_READY;
            cnt_q       <= 4'd0;
            pending_q   <= 8'h00;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            res_valid_q <= res_valid_d;
        end
    end

endmodule
